// File: rtl/multicycle_cu_rv32i.sv
// ============================================================================
//  Module      : multicycle_cu_rv32i
//  Description : Multi-cycle control unit for an RV32I datapath. Accepts one
//                instruction per valid/ready handshake and sequences it through
//                FETCH/DECODE/EXEC/MEM/WB. It counts retired instructions and
//                bounds data-memory waits with a timeout.
//  Options     : ILLEGAL_TRAP_EN - when defined, an illegal opcode parks the
//                unit in TRAP until reset and raises illegal_trap. When it is
//                undefined, an illegal opcode retires as a NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_cu_rv32i #(
    parameter int MEM_TIMEOUT = 15,   // 1..255 cycles of MEM wait before abort
    parameter int CNT_W       = 32    // retired-instruction counter width
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    input  logic             mem_ack,
    output logic [24:0]      trimmed_instr,
    output logic [2:0]       cu_immtype,
    output logic             cu_alusrc,
    output logic             cu_memread,
    output logic             cu_memwrite,
    output logic             cu_regwrite,
    output logic             cu_branch,
    output logic             cu_jump,
    output logic             pc_en,
    output logic             mem_err,
`ifdef ILLEGAL_TRAP_EN
    output logic             illegal_trap,
`endif
    output logic [CNT_W-1:0] instret
);

    // ------------------------------------------------------------------------
    // Opcode and immediate-type encodings
    // ------------------------------------------------------------------------
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    localparam logic [2:0] c_IMM_I = 3'b000;
    localparam logic [2:0] c_IMM_S = 3'b001;
    localparam logic [2:0] c_IMM_B = 3'b010;
    localparam logic [2:0] c_IMM_U = 3'b011;
    localparam logic [2:0] c_IMM_J = 3'b100;

    localparam logic [7:0] c_TIMEOUT = 8'(MEM_TIMEOUT);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_instr_q;
    logic [7:0]        r_cnt;
    logic [CNT_W-1:0]  r_instret;

    logic [6:0]        w_opcode;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_is_branch;
    logic              w_is_jump;
    logic              w_is_illegal;
    logic [2:0]        w_immtype;
    logic              w_alusrc;

    logic              w_accept;
    logic              w_retire;
    logic              w_memread;
    logic              w_memwrite;
    logic              w_regwrite;
    logic              w_branch;
    logic              w_jump;
    logic              w_pc_en;
    logic              w_mem_err;

    assign w_opcode = r_instr_q[6:0];
    // Ready is also gated by reset so the source never sees ready while the
    // unit is held in reset.
    assign w_accept = instr_valid & instr_ready;

    // Classify the latched instruction and pick its immediate format.
    always_comb begin
        w_is_load    = 1'b0;
        w_is_store   = 1'b0;
        w_is_branch  = 1'b0;
        w_is_jump    = 1'b0;
        w_is_illegal = 1'b0;
        w_immtype    = c_IMM_I;
        w_alusrc     = 1'b0;
        case (w_opcode)
            c_OP_IMM: begin
                w_immtype = c_IMM_I;
                w_alusrc  = 1'b1;
            end
            c_OP_LOAD: begin
                w_is_load = 1'b1;
                w_immtype = c_IMM_I;
                w_alusrc  = 1'b1;
            end
            c_OP_JALR: begin
                w_is_jump = 1'b1;
                w_immtype = c_IMM_I;
                w_alusrc  = 1'b1;
            end
            c_OP_STORE: begin
                w_is_store = 1'b1;
                w_immtype  = c_IMM_S;
                w_alusrc   = 1'b1;
            end
            c_OP_BRANCH: begin
                // Branch compares two registers; the offset goes to the PC adder.
                w_is_branch = 1'b1;
                w_immtype   = c_IMM_B;
                w_alusrc    = 1'b0;
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_immtype = c_IMM_U;
                w_alusrc  = 1'b1;
            end
            c_OP_JAL: begin
                w_is_jump = 1'b1;
                w_immtype = c_IMM_J;
                w_alusrc  = 1'b1;
            end
            c_OP_REG: begin
                w_immtype = c_IMM_I;
                w_alusrc  = 1'b0;
            end
            default: begin
                w_is_illegal = 1'b1;
            end
        endcase
    end

    // State register; an asynchronous reset aborts any instruction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_memread   = 1'b0;
        w_memwrite  = 1'b0;
        w_regwrite  = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_pc_en     = 1'b0;
        w_mem_err   = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_accept) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                w_state_nxt = w_is_illegal ? S_TRAP : S_EXEC;
`else
                w_state_nxt = S_EXEC;
`endif
            end
            S_EXEC: begin
                if (w_is_branch) begin
                    // Branches resolve here and retire without WB.
                    w_branch    = 1'b1;
                    w_pc_en     = 1'b1;
                    w_retire    = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (w_is_load || w_is_store) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_MEM: begin
                w_memread  = w_is_load;
                w_memwrite = w_is_store;
                if (mem_ack) begin
                    // An ack takes priority over a timeout in the same cycle.
                    if (w_is_store) begin
                        w_pc_en     = 1'b1;
                        w_retire    = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end else if (r_cnt == c_TIMEOUT) begin
                    // Abort: advance the PC but do not count the instruction.
                    w_mem_err   = 1'b1;
                    w_pc_en     = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_WB: begin
                // An illegal opcode reaches WB only as a NOP and writes nothing.
                w_regwrite  = ~w_is_illegal;
                w_jump      = w_is_jump;
                w_pc_en     = 1'b1;
                w_retire    = 1'b1;
                w_state_nxt = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                w_state_nxt = S_TRAP;
            end
`endif
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // Latch the instruction word on the accepting handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_instr_q <= 32'd0;
        end else if (w_accept) begin
            r_instr_q <= instr;
        end
    end

    // Count MEM cycles without an ack; the count is zero on every MEM entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else if ((r_state == S_MEM) && !mem_ack && (r_cnt != c_TIMEOUT)) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= 8'd0;
        end
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + 1'b1;
        end
    end

    assign instr_ready   = (r_state == S_FETCH) & ~reset;
    assign trimmed_instr = r_instr_q[31:7];
    assign cu_immtype    = w_immtype;
    assign cu_alusrc     = w_alusrc;
    assign cu_memread    = w_memread;
    assign cu_memwrite   = w_memwrite;
    assign cu_regwrite   = w_regwrite;
    assign cu_branch     = w_branch;
    assign cu_jump       = w_jump;
    assign pc_en         = w_pc_en;
    assign mem_err       = w_mem_err;
    assign instret       = r_instret;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_trap  = (r_state == S_TRAP);
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_cu_rv32i.sv
// ============================================================================
//  Module      : tb_multicycle_cu_rv32i
//  Description : Directed self-checking bench for multicycle_cu_rv32i, with
//                CNT_W=4 so that the instret wrap can be reached.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_cu_rv32i;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 4;

    // Strobe vector bit order: {memread, memwrite, regwrite, branch, jump, pc_en, mem_err}
    localparam logic [6:0] c_NONE  = 7'b0000000;
    localparam logic [6:0] c_RDMEM = 7'b1000000;
    localparam logic [6:0] c_WRMEM = 7'b0100000;
    localparam logic [6:0] c_WB    = 7'b0010010;
    localparam logic [6:0] c_WBJ   = 7'b0010110;
    localparam logic [6:0] c_NOPWB = 7'b0000010;
    localparam logic [6:0] c_BR    = 7'b0001010;
    localparam logic [6:0] c_STACK = 7'b0100010;
    localparam logic [6:0] c_ABORT = 7'b1000011;

    logic             clock;
    logic             reset;
    logic             instr_valid;
    logic [31:0]      instr;
    logic             instr_ready;
    logic             mem_ack;
    logic [24:0]      trimmed_instr;
    logic [2:0]       cu_immtype;
    logic             cu_alusrc;
    logic             cu_memread;
    logic             cu_memwrite;
    logic             cu_regwrite;
    logic             cu_branch;
    logic             cu_jump;
    logic             pc_en;
    logic             mem_err;
`ifdef ILLEGAL_TRAP_EN
    logic             illegal_trap;
`endif
    logic [CNT_W-1:0] instret;

    int n_pass;
    int n_total;

    multicycle_cu_rv32i #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_dut (
        .clock         (clock),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .mem_ack       (mem_ack),
        .trimmed_instr (trimmed_instr),
        .cu_immtype    (cu_immtype),
        .cu_alusrc     (cu_alusrc),
        .cu_memread    (cu_memread),
        .cu_memwrite   (cu_memwrite),
        .cu_regwrite   (cu_regwrite),
        .cu_branch     (cu_branch),
        .cu_jump       (cu_jump),
        .pc_en         (pc_en),
        .mem_err       (mem_err),
`ifdef ILLEGAL_TRAP_EN
        .illegal_trap  (illegal_trap),
`endif
        .instret       (instret)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] strobes();
        return {cu_memread, cu_memwrite, cu_regwrite, cu_branch, cu_jump, pc_en, mem_err};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer an instruction in FETCH and complete the handshake; ends in DECODE.
    task automatic send(input logic [31:0] word);
        instr       = word;
        instr_valid = 1'b1;
        chk("ready_in_fetch", {31'd0, instr_ready}, 32'd1);
        tick();
        instr_valid = 1'b0;
        chk("trimmed", {7'd0, trimmed_instr}, {7'd0, word[31:7]});
    endtask

    // Plain three-cycle instruction: DECODE, EXEC, WB, then back in FETCH.
    task automatic run3(input string tag, input logic [31:0] word, input logic [2:0] imm,
                        input logic [6:0] wb, input logic [CNT_W-1:0] cnt_after);
        send(word);
        chk({tag, "_imm"}, {29'd0, cu_immtype}, {29'd0, imm});
        chk({tag, "_dec"}, {25'd0, strobes()}, {25'd0, c_NONE});
        tick();
        chk({tag, "_exec"}, {25'd0, strobes()}, {25'd0, c_NONE});
        tick();
        chk({tag, "_wb"}, {25'd0, strobes()}, {25'd0, wb});
        tick();
        chk({tag, "_instret"}, {28'd0, instret}, {28'd0, cnt_after});
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr       = 32'h0050_0093;
        mem_ack     = 1'b0;

        // Reset: valid is offered but must not be accepted.
        tick();
        tick();
        chk("rst_ready",   {31'd0, instr_ready},   32'd0);
        chk("rst_strobes", {25'd0, strobes()},     32'd0);
        chk("rst_instret", {28'd0, instret},       32'd0);
        chk("rst_trimmed", {7'd0, trimmed_instr},  32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, instr_ready}, 32'd1);

        // addi x1,x0,5
        send(32'h0050_0093);
        chk("addi_alusrc", {31'd0, cu_alusrc}, 32'd1);
        tick();
        tick();
        chk("addi_wb", {25'd0, strobes()}, {25'd0, c_WB});
        tick();
        chk("addi_instret", {28'd0, instret}, 32'd1);
        chk("addi_fetch_strobes", {25'd0, strobes()}, 32'd0);

        // sw x1,8(x2), ack on the second MEM cycle
        send(32'h0011_2423);
        chk("sw_imm", {29'd0, cu_immtype}, 32'd1);
        tick();
        chk("sw_exec", {25'd0, strobes()}, {25'd0, c_NONE});
        tick();
        chk("sw_mem1", {25'd0, strobes()}, {25'd0, c_WRMEM});
        mem_ack = 1'b1;
        #1;
        chk("sw_mem2", {25'd0, strobes()}, {25'd0, c_STACK});
        tick();
        mem_ack = 1'b0;
        chk("sw_ready", {31'd0, instr_ready}, 32'd1);
        chk("sw_instret", {28'd0, instret}, 32'd2);

        // lw x3,0(x2), ack withheld: abort after MEM_TIMEOUT wait cycles
        send(32'h0001_2183);
        chk("lw_imm", {29'd0, cu_immtype}, 32'd0);
        tick();
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            tick();
            chk("lw_wait", {25'd0, strobes()}, {25'd0, c_RDMEM});
        end
        tick();
        chk("lw_abort", {25'd0, strobes()}, {25'd0, c_ABORT});
        tick();
        chk("lw_ready", {31'd0, instr_ready}, 32'd1);
        chk("lw_instret", {28'd0, instret}, 32'd2);

        // beq x0,x0,8
        send(32'h0000_0463);
        chk("beq_imm",    {29'd0, cu_immtype}, 32'd2);
        chk("beq_alusrc", {31'd0, cu_alusrc},  32'd0);
        tick();
        chk("beq_exec", {25'd0, strobes()}, {25'd0, c_BR});
        tick();
        chk("beq_ready", {31'd0, instr_ready}, 32'd1);
        chk("beq_instret", {28'd0, instret}, 32'd3);

        // jal x1,16 and add x1,x2,x3
        run3("jal", 32'h0100_00EF, 3'b100, c_WBJ, 4'd4);
        instr = 32'h0031_00B3;
        run3("add", 32'h0031_00B3, 3'b000, c_WB, 4'd5);

        // Fill the counter to 15, then lui wraps it to 0.
        for (int i = 6; i <= 15; i++) begin
            run3("fill", 32'h0050_0093, 3'b000, c_WB, 4'(i));
        end
        run3("lui", 32'h1234_50B7, 3'b011, c_WB, 4'd0);

`ifdef ILLEGAL_TRAP_EN
        // Illegal opcode parks in TRAP until reset.
        send(32'h0000_007F);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("trap_flag",    {31'd0, illegal_trap}, 32'd1);
            chk("trap_ready",   {31'd0, instr_ready},  32'd0);
            chk("trap_strobes", {25'd0, strobes()},    32'd0);
        end
        chk("trap_instret", {28'd0, instret}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("trap_cleared", {31'd0, illegal_trap}, 32'd0);
`else
        // Illegal opcode retires as a NOP.
        run3("nop", 32'h0000_007F, 3'b000, c_NOPWB, 4'd1);
`endif

        // Reset in the middle of MEM kills every strobe at once.
        send(32'h0001_2183);
        tick();
        tick();
        chk("mid_mem", {25'd0, strobes()}, {25'd0, c_RDMEM});
        reset = 1'b1;
        #1;
        chk("mid_rst_strobes", {25'd0, strobes()}, 32'd0);
        chk("mid_rst_ready",   {31'd0, instr_ready}, 32'd0);
        chk("mid_rst_instret", {28'd0, instret},   32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_release", {31'd0, instr_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
